// File: rtl/mux_nx1_pipe_if.sv
// Valid/ready bus for mux_nx1_pipe: select-side inputs and registered output beat.
// The master drives In/Sel/InValid/OutReady and the slave (the mux) drives the rest.
interface mux_nx1_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*WIDTH-1:0] In;
  logic [SEL_W-1:0]        Sel;
  logic                    InValid;
  logic                    InReady;
  logic [WIDTH-1:0]        Y;
  logic                    SelErr;
  logic                    OutValid;
  logic                    OutReady;

  modport master (
    output In, Sel, InValid, OutReady,
    input  InReady, Y, SelErr, OutValid
  );

  modport slave (
    input  In, Sel, InValid, OutReady,
    output InReady, Y, SelErr, OutValid
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 mux with valid/ready on both sides and a 2-entry skid buffer.
//  state | meaning
//  EMPTY | no beat held, output idle
//  ONE   | main register holds the output beat
//  FULL  | main holds the output beat, skid holds the next one; input stalled
module mux_nx1_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  mux_nx1_pipe_if.slave bus
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_data, skid_data, cap_data;
  logic             main_err, skid_err, cap_err;
  logic             in_ready, out_valid, accept, drain;
  logic             load_main, load_skid, main_from_skid;

  // Ready/valid come only from the state register: no OutReady->InReady path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = bus.InValid & in_ready;
  assign drain     = out_valid & bus.OutReady;

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.Y        = main_data;
  assign bus.SelErr   = main_err;

  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.Sel == SEL_W'(k)) begin
        cap_data = bus.In[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_main = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_nxt      = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_data <= cap_data;
        main_err  <= cap_err;
      end else if (main_from_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= cap_data;
        skid_err  <= cap_err;
      end
    end
  end
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed and randomized checks of mux_nx1_pipe in three configurations
// against a queue-based model of the handshake behaviour.
module tb_mux_nx1_pipe;
  logic Clk;
  logic Reset_n;
  int   tests = 0;
  int   fails = 0;

  mux_nx1_pipe_if #(.WIDTH(8), .NUM_IN(4)) ia ();
  mux_nx1_pipe_if #(.WIDTH(1), .NUM_IN(2)) ib ();
  mux_nx1_pipe_if #(.WIDTH(8), .NUM_IN(3)) ic ();

  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(4)) dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(ia));
  mux_nx1_pipe #(.WIDTH(1), .NUM_IN(2)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(ib));
  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(3)) dut_c (.Clk(Clk), .Reset_n(Reset_n), .bus(ic));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [8:0]  mq[$];
  logic [2:0]  v;
  logic [31:0] r;
  logic [7:0]  d;
  logic        e;
  int          sel;
  bit          acc, drn;
  int          acc_n, out_n, cyc;

  initial begin
    Reset_n = 1'b0;
    ia.In = '0; ia.Sel = '0; ia.InValid = 1'b0; ia.OutReady = 1'b0;
    ib.In = '0; ib.Sel = '0; ib.InValid = 1'b0; ib.OutReady = 1'b0;
    ic.In = '0; ic.Sel = '0; ic.InValid = 1'b0; ic.OutReady = 1'b0;
    #2;
    chk("rst_a_ready", ia.InReady, 1);
    chk("rst_a_valid", ia.OutValid, 0);
    chk("rst_a_y", ia.Y, 0);
    chk("rst_a_err", ia.SelErr, 0);
    chk("rst_c_ready", ic.InReady, 1);
    #10 Reset_n = 1'b1;
    step();

    // legacy 2x1, 1 bit
    ib.OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      ib.In = v[1:0]; ib.Sel = v[2]; ib.InValid = 1'b1;
      step();
      chk("legacy_y", ib.Y, v[2] ? v[1] : v[0]);
      chk("legacy_valid", ib.OutValid, 1);
      chk("legacy_err", ib.SelErr, 0);
    end
    ib.InValid = 1'b0;
    step();
    chk("legacy_idle", ib.OutValid, 0);

    // streaming
    ia.In = 32'h44332211; ia.OutReady = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ia.Sel = 2'(s); ia.InValid = 1'b1;
      step();
      chk("stream_y", ia.Y, (s + 1) * 32'h11);
      chk("stream_ready", ia.InReady, 1);
      chk("stream_err", ia.SelErr, 0);
      chk("stream_valid", ia.OutValid, 1);
    end
    ia.InValid = 1'b0;
    step();
    chk("stream_idle", ia.OutValid, 0);

    // back-pressure
    ia.OutReady = 1'b0;
    ia.Sel = 2'd1; ia.InValid = 1'b1;
    step();
    chk("bp_y1", ia.Y, 8'h22);
    chk("bp_ready1", ia.InReady, 1);
    ia.Sel = 2'd2;
    step();
    chk("bp_y2", ia.Y, 8'h22);
    chk("bp_ready2", ia.InReady, 0);
    ia.InValid = 1'b0; ia.Sel = 2'd3;
    step();
    chk("bp_hold_y", ia.Y, 8'h22);
    chk("bp_hold_ready", ia.InReady, 0);
    chk("bp_hold_valid", ia.OutValid, 1);
    ia.OutReady = 1'b1;
    step();
    chk("bp_y3", ia.Y, 8'h33);
    chk("bp_ready3", ia.InReady, 1);
    chk("bp_valid3", ia.OutValid, 1);
    step();
    chk("bp_empty", ia.OutValid, 0);
    chk("bp_ready4", ia.InReady, 1);

    // out-of-range select
    ic.In = 24'h332211; ic.OutReady = 1'b1; ic.InValid = 1'b1;
    ic.Sel = 2'd3;
    step();
    chk("oor_y", ic.Y, 0);
    chk("oor_err", ic.SelErr, 1);
    ic.Sel = 2'd0;
    step();
    chk("oor_next_y", ic.Y, 8'h11);
    chk("oor_next_err", ic.SelErr, 0);
    ic.Sel = 2'd2;
    step();
    chk("oor_sel2_y", ic.Y, 8'h33);
    ic.InValid = 1'b0;
    step();

    // reset while FULL
    ia.OutReady = 1'b0; ia.InValid = 1'b1;
    ia.Sel = 2'd0;
    step();
    ia.Sel = 2'd3;
    step();
    chk("rf_full", ia.InReady, 0);
    ia.InValid = 1'b0;
    #3 Reset_n = 1'b0;
    #1;
    chk("rf_valid", ia.OutValid, 0);
    chk("rf_y", ia.Y, 0);
    chk("rf_ready", ia.InReady, 1);
    chk("rf_err", ia.SelErr, 0);
    #2 Reset_n = 1'b1;
    ia.OutReady = 1'b1;
    step();
    chk("rf_post1", ia.OutValid, 0);
    step();
    chk("rf_post2", ia.OutValid, 0);
    chk("rf_post_ready", ia.InReady, 1);

    // random traffic on the 3-input instance, queue model
    acc_n = 0; out_n = 0; cyc = 0;
    while (acc_n < 2000 && cyc < 20000) begin
      chk("rnd_ready", ic.InReady, (mq.size() < 2) ? 1 : 0);
      chk("rnd_valid", ic.OutValid, (mq.size() > 0) ? 1 : 0);
      if (mq.size() > 0) begin
        chk("rnd_y", ic.Y, mq[0][7:0]);
        chk("rnd_err", ic.SelErr, mq[0][8]);
      end
      r = $urandom;
      ic.In = r[23:0];
      sel = $urandom_range(0, 3);
      ic.Sel = 2'(sel);
      ic.InValid = 1'($urandom_range(0, 1));
      ic.OutReady = 1'($urandom_range(0, 1));
      acc = ic.InValid && (mq.size() < 2);
      drn = ic.OutReady && (mq.size() > 0);
      if (sel < 3) begin
        d = r[sel*8 +: 8]; e = 1'b0;
      end else begin
        d = 8'h00; e = 1'b1;
      end
      step();
      cyc++;
      if (drn) begin
        void'(mq.pop_front());
        out_n++;
      end
      if (acc) begin
        mq.push_back({e, d});
        acc_n++;
      end
    end
    chk("rnd_accepted", acc_n, 2000);
    ic.InValid = 1'b0; ic.OutReady = 1'b1;
    for (int i = 0; i < 4 && mq.size() > 0; i++) begin
      chk("rnd_tail_valid", ic.OutValid, 1);
      chk("rnd_tail_y", ic.Y, mq[0][7:0]);
      chk("rnd_tail_err", ic.SelErr, mq[0][8]);
      step();
      void'(mq.pop_front());
      out_n++;
    end
    chk("rnd_drained", ic.OutValid, 0);
    chk("rnd_out_count", out_n, 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
